// File: rtl/pa_cmd_responder.sv
// PA-side UART command responder: collects 4-byte command frames, applies enable
// writes, and returns a 5-byte response after a fixed delay via a valid/ready byte port.
module pa_cmd_responder #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int RESP_DLY    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_vld,
    output logic [7:0] tx_byte,
    output logic       tx_vld,
    input  logic       tx_rdy,
    input  logic [7:0] pa_temp_in,
    input  logic [3:0] pa_alarm_in,
    output logic       pa_en,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state
);
    // Handshake: a tx byte moves on any clk edge where tx_vld && tx_rdy; tx_byte
    // and tx_vld hold while tx_rdy is low. rx_vld is a one-cycle strobe with no backpressure.

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int DW = (RESP_DLY > 1) ? $clog2(RESP_DLY) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX     = 3'd1,
        S_DECODE = 3'd2,
        S_WAIT   = 3'd3,
        S_TX     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [24:0]   cmd_q, cmd_d;     // only bit 0 of the data byte matters
    logic [TW-1:0] tmo_q, tmo_d;
    logic [DW-1:0] dly_q, dly_d;
    logic [39:0]   resp_q, resp_d;
    logic [2:0]    idx_q, idx_d;
    logic          pa_en_q, pa_en_d;
    logic          ferr_q, ferr_d;

    logic          dec_nak;
    logic          dec_en;
    logic [7:0]    dec_d0;
    logic [7:0]    dec_d1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            tmo_q   <= '0;
            dly_q   <= '0;
            resp_q  <= '0;
            idx_q   <= '0;
            pa_en_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            tmo_q   <= tmo_d;
            dly_q   <= dly_d;
            resp_q  <= resp_d;
            idx_q   <= idx_d;
            pa_en_q <= pa_en_d;
            ferr_q  <= ferr_d;
        end
    end

    // Command decode; temperature/alarm are read live so DECODE latches a snapshot.
    always_comb begin
        dec_nak = 1'b1;
        dec_en  = pa_en_q;
        dec_d0  = 8'hEE;
        dec_d1  = 8'hEE;
        if (cmd_q[15:8] == 8'h01) begin
            if (cmd_q[7:0] == 8'h03 && cmd_q[23:16] == 8'h01) begin
                dec_nak = 1'b0;
                dec_en  = cmd_q[24];
                dec_d0  = {7'b0, cmd_q[24]};
                dec_d1  = 8'h00;
            end else if (cmd_q[7:0] == 8'h02) begin
                case (cmd_q[23:16])
                    8'h01: begin
                        dec_nak = 1'b0;
                        dec_d0  = {7'b0, pa_en_q};
                        dec_d1  = 8'h00;
                    end
                    8'h03: begin
                        dec_nak = 1'b0;
                        dec_d0  = pa_temp_in;
                        dec_d1  = 8'h00;
                    end
                    8'h04: begin
                        dec_nak = 1'b0;
                        dec_d0  = {3'b0, pa_alarm_in[3], 3'b0, pa_alarm_in[2]};
                        dec_d1  = {3'b0, pa_alarm_in[1], 3'b0, pa_alarm_in[0]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        tmo_d   = tmo_q;
        dly_d   = dly_q;
        resp_d  = resp_q;
        idx_d   = idx_q;
        pa_en_d = pa_en_q;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (rx_vld) begin
                    cmd_d[7:0] = rx_byte;
                    cnt_d      = 2'd1;
                    state_d    = S_RX;
                end
            end
            S_RX: begin
                if (tmo_q == TW'(TIMEOUT_CYC)) begin
                    // Timeout beats a coincident byte, which then opens a fresh frame.
                    ferr_d = 1'b1;
                    tmo_d  = '0;
                    if (rx_vld) begin
                        cmd_d[7:0] = rx_byte;
                        cnt_d      = 2'd1;
                    end else begin
                        cnt_d   = 2'd0;
                        state_d = S_IDLE;
                    end
                end else if (rx_vld) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd1:    cmd_d[15:8]  = rx_byte;
                        2'd2:    cmd_d[23:16] = rx_byte;
                        default: begin
                            cmd_d[24] = rx_byte[0];
                            cnt_d     = 2'd0;
                            state_d   = S_DECODE;
                        end
                    endcase
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DECODE: begin
                pa_en_d = dec_en;
                resp_d  = {dec_d0, dec_d1, cmd_q[23:0]};
                ferr_d  = dec_nak | rx_vld;
                dly_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ferr_d = rx_vld;
                if (dly_q == DW'(RESP_DLY - 1)) begin
                    dly_d   = '0;
                    idx_d   = 3'd0;
                    state_d = S_TX;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            S_TX: begin
                ferr_d = rx_vld;
                if (tx_rdy) begin
                    if (idx_q == 3'd4) begin
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_vld    = (state_q == S_TX);
        tx_byte   = tx_vld ? resp_q[{idx_q, 3'b000} +: 8] : 8'h00;
        busy      = (state_q != S_IDLE);
        dbg_state = state_q;
        pa_en     = pa_en_q;
        frame_err = ferr_q;
    end

endmodule

// File: tb/tb_pa_cmd_responder.sv
// Bench for pa_cmd_responder: table of command frames with expected responses,
// plus hand-written timeout, backpressure/drop and reset-mid-TX sequences.
module tb_pa_cmd_responder;
    localparam int T        = 40;
    localparam int RESP_DLY = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_vld;
    logic [7:0] tx_byte;
    logic       tx_vld;
    logic       tx_rdy;
    logic [7:0] pa_temp_in;
    logic [3:0] pa_alarm_in;
    logic       pa_en;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    pa_cmd_responder #(.TIMEOUT_CYC(T), .RESP_DLY(RESP_DLY)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_vld(rx_vld),
        .tx_byte(tx_byte), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .pa_temp_in(pa_temp_in), .pa_alarm_in(pa_alarm_in),
        .pa_en(pa_en), .frame_err(frame_err), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cmd;    // wire order, B0 in the top byte
        logic [7:0]  temp;
        logic [3:0]  alarm;
        logic [39:0] resp;   // wire order, first byte in the top byte
        logic        en;
        int          fe;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    int         fe_cnt = 0;
    logic       cur_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] cmd, input logic [7:0] temp,
                                input logic [3:0] alarm, input logic [39:0] resp,
                                input logic en, input int fe);
        vec_t v;
        v.cmd = cmd; v.temp = temp; v.alarm = alarm; v.resp = resp; v.en = en; v.fe = fe;
        return v;
    endfunction

    // Scoreboard: every byte offered with tx_rdy high is popped and compared.
    always begin
        @(negedge clk);
        #1;
        if (!rst && tx_vld && tx_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx_byte", {56'h0, tx_byte}, 64'hFFFF);
            end else begin
                check("tx_byte", {56'h0, tx_byte}, {56'h0, exp_q.pop_front()});
            end
        end
        if (frame_err) fe_cnt++;
    end

    task automatic send(input logic [7:0] b);
        rx_byte = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
    endtask

    task automatic push_resp(input logic [39:0] r);
        for (int i = 0; i < 5; i++) exp_q.push_back(r[39-8*i -: 8]);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_in_budget", n < 300, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_tx_vld();
        int n = 0;
        while (!tx_vld && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("tx_vld_seen", tx_vld, 1);
    endtask

    task automatic run_frame(input vec_t v);
        int cyc = 0;
        int fe0;
        @(negedge clk);
        pa_temp_in  = v.temp;
        pa_alarm_in = v.alarm;
        push_resp(v.resp);
        fe0 = fe_cnt;
        for (int i = 0; i < 4; i++) send(v.cmd[31-8*i -: 8]);
        check("pa_en_pre", pa_en, cur_en);
        while (!tx_vld && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1) check("pa_en_upd", pa_en, v.en);
        end
        check("first_tx_lat", cyc, RESP_DLY + 1);
        wait_done();
        check("frame_err_cnt", fe_cnt - fe0, v.fe);
        cur_en = v.en;
    endtask

    initial begin
        int fe0;
        logic [7:0] rt;
        logic [3:0] ra;
        rst = 1'b1; rx_byte = 8'h00; rx_vld = 1'b0; tx_rdy = 1'b1;
        pa_temp_in = 8'h00; pa_alarm_in = 4'h0;

        vecs.push_back(mk(32'h03010101, 8'h00, 4'h0, 40'h0301010001, 1'b1, 0));
        vecs.push_back(mk(32'h03010100, 8'h00, 4'h0, 40'h0301010000, 1'b0, 0));
        vecs.push_back(mk(32'h02010100, 8'h00, 4'h0, 40'h0201010000, 1'b0, 0));
        vecs.push_back(mk(32'h02010300, 8'h2A, 4'hA, 40'h020103002A, 1'b0, 0));
        vecs.push_back(mk(32'h02010400, 8'h2A, 4'hA, 40'h0201041010, 1'b0, 0));
        vecs.push_back(mk(32'h02010400, 8'h2A, 4'hC, 40'h0201040011, 1'b0, 0));
        vecs.push_back(mk(32'h03010101, 8'h00, 4'h0, 40'h0301010001, 1'b1, 0));
        vecs.push_back(mk(32'h03010405, 8'h00, 4'h0, 40'h030104EEEE, 1'b1, 1));
        vecs.push_back(mk(32'h02050100, 8'h00, 4'h0, 40'h020501EEEE, 1'b1, 1));
        vecs.push_back(mk(32'h07010100, 8'h00, 4'h0, 40'h070101EEEE, 1'b1, 1));
        vecs.push_back(mk(32'h02010900, 8'h00, 4'h0, 40'h020109EEEE, 1'b1, 1));
        vecs.push_back(mk(32'h02010100, 8'h00, 4'h0, 40'h0201010001, 1'b1, 0));
        vecs.push_back(mk(32'h030101FE, 8'h00, 4'h0, 40'h0301010000, 1'b0, 0));
        rt = 8'($urandom_range(0, 255));
        ra = 4'($urandom_range(0, 15));
        vecs.push_back(mk(32'h02010300, rt, ra, {24'h020103, 8'h00, rt}, 1'b0, 0));
        vecs.push_back(mk(32'h02010400, rt, ra,
                          {24'h020104, 3'b0, ra[1], 3'b0, ra[0], 3'b0, ra[3], 3'b0, ra[2]},
                          1'b0, 0));

        repeat (3) @(negedge clk);
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_pa_en", pa_en, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_frame(vecs[i]);

        // Partial frame then idle past the timeout: discarded, one error, one response.
        fe0 = fe_cnt;
        pa_temp_in = 8'h2A;
        push_resp(40'h020103002A);
        send(8'h02); send(8'h01);
        repeat (T + 1) @(negedge clk);
        check("timeout_to_idle", busy, 0);
        send(8'h02); send(8'h01); send(8'h03); send(8'h00);
        wait_done();
        check("timeout_fe", fe_cnt - fe0, 1);

        // Byte arriving in the very cycle the timeout fires starts a new frame.
        fe0 = fe_cnt;
        pa_temp_in = 8'h5C;
        push_resp(40'h020103005C);
        send(8'h02); send(8'h01);
        repeat (T) @(negedge clk);
        send(8'h02); send(8'h01); send(8'h03); send(8'h00);
        wait_done();
        check("collide_fe", fe_cnt - fe0, 1);

        // Backpressure on the second byte, plus a byte dropped during TX.
        tx_rdy = 1'b0;
        push_resp({32'h02010100, 7'b0, cur_en});
        send(8'h02); send(8'h01); send(8'h01); send(8'h00);
        wait_tx_vld();
        @(negedge clk); tx_rdy = 1'b1;
        @(negedge clk); tx_rdy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            check("hold_tx_vld", tx_vld, 1);
            check("hold_tx_byte", tx_byte, 8'h01);
        end
        fe0 = fe_cnt;
        send(8'h55);
        @(negedge clk); tx_rdy = 1'b1;
        wait_done();
        check("drop_fe", fe_cnt - fe0, 1);

        // Reset after two bytes of a response have gone out.
        run_frame(mk(32'h03010101, 8'h00, 4'h0, 40'h0301010001, 1'b1, 0));
        push_resp(40'h0201010001);
        send(8'h02); send(8'h01); send(8'h01); send(8'h00);
        wait_tx_vld();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_tx_vld", tx_vld, 0);
        check("rst_mid_pa_en", pa_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pending", exp_q.size(), 3);
        exp_q.delete();
        cur_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_no_tx", tx_vld, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(mk(32'h02010100, 8'h00, 4'h0, 40'h0201010000, 1'b0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pa_cmd_responder.md
# pa_cmd_responder

Power-amplifier-side responder for the FPGA↔PA UART command link. It receives 4-byte command frames from a UART byte receiver and decodes read/write opcodes. It updates the PA enable state and returns a 5-byte response frame through a UART byte transmitter. It sits behind the PA serial port on the amplifier control board, or in the loopback harness that exercises the FPGA-side PA controller.

## Interface
- TIMEOUT_CYC, 50000: max idle cycles between bytes of one command frame (1 ms at 50 MHz); counter width $clog2(TIMEOUT_CYC+1).
- RESP_DLY, 16: cycles between command decode and first response byte offered; ≥1.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset; one clock, reset is asynchronous and active-high.
- rx_byte  in  8  received byte from UART RX.
- rx_vld  in  1  one-cycle strobe; rx_byte valid.
- tx_byte  out  8  byte to UART TX.
- tx_vld  out  1  tx_byte valid; held until accepted.
- tx_rdy  in  1  UART TX accepts byte when tx_vld && tx_rdy at clk edge.
- pa_temp_in  in  8  current PA temperature code.
- pa_alarm_in  in  4  PA status bits {a,b,c,d} (bit 3 = a).
- pa_en  out  1  PA enable (1 = transmit enabled).
- frame_err  out  1  one-cycle pulse on timeout, bad frame, or dropped byte.
- busy  out  1  high in any state other than IDLE.

## Operation
- Command frame, wire order: B0 = cmd[7:0] opcode (0x02 read, 0x03 write), B1 = cmd[15:8] header (must be 0x01), B2 = cmd[23:16] register, B3 = cmd[31:24] data.
- Registers:
  - 0x01 = enable (R/W).
  - 0x03 = temperature (R).
  - 0x04 = status (R).
- Response, 40 bits, wire order LSB byte first: bytes 0–2 = cmd[23:0] echo, byte 3 = D1, byte 4 = D0.
- Read 0x01: D0 = {7'b0,pa_en}, D1 = 0x00.
- Read 0x03: D0 = pa_temp_in, D1 = 0x00.
- Read 0x04: D0 = {3'b0,a,3'b0,b}, D1 = {3'b0,c,3'b0,d}.
- Write 0x01: pa_en ← B3[0] (B3[7:1] ignored); response D0 = {7'b0,new pa_en}, D1 = 0x00.
- NAK condition: B1 ≠ 0x01, opcode not 0x02/0x03, write to any register other than 0x01, or read of an undefined register.
- On NAK: D0 = D1 = 0xEE, pa_en unchanged, frame_err pulses once at decode.
- pa_temp_in and pa_alarm_in are sampled in the DECODE cycle; the response is built from that snapshot.
- FSM states:
  - IDLE: first rx_vld → RX, byte count = 1.
  - RX: collect bytes; 4th byte → DECODE. If the inter-byte counter reaches TIMEOUT_CYC → IDLE, discard partial frame, pulse frame_err.
  - DECODE (1 cycle): apply write, latch response → WAIT.
  - WAIT: count RESP_DLY cycles → TX.
  - TX: present 5 bytes in order with the valid/ready handshake; after the 5th accepted byte → IDLE.
- rx_vld during DECODE/WAIT/TX: byte dropped, frame_err pulses, current response unaffected.
- rx_vld in the same cycle the timeout fires: timeout wins; that byte starts a new frame (count = 1, state RX), frame_err pulses.

## Timing
- Reset values (asynchronous, immediate): pa_en = 0, tx_vld = 0, tx_byte = 0x00, frame_err = 0, busy = 0, state IDLE, all counters 0. Assertion of rst mid-frame or mid-TX aborts with no further bytes.
- Last command byte sampled at edge N: DECODE during cycle N→N+1; pa_en updates at edge N+1.
- tx_vld first high after edge N+1+RESP_DLY, i.e. RESP_DLY+1 cycles after last RX byte.
- tx_byte is stable while tx_vld && !tx_rdy. Next byte is presented the cycle after acceptance; with tx_rdy held high, one byte per cycle.
- tx_vld deasserts the cycle after the 5th acceptance; busy falls in the same cycle.
- Inter-byte timeout counter resets on each accepted rx byte and counts only in RX.

## Test plan
- Enable write: rx 03 01 01 01 → pa_en 0→1 one cycle after last byte; response 03 01 01 00 01, first tx_vld at RESP_DLY+1 cycles.
- Disable write then read enable: rx 03 01 01 00, then 02 01 01 00 → pa_en = 0; responses 03 01 01 00 00 and 02 01 01 00 00.
- Temp/status reads: pa_temp_in = 0x2A, pa_alarm_in = 4'b1010; rx 02 01 03 00 → 02 01 03 00 2A; rx 02 01 04 00 → 02 01 04 10 10.
- Errors:
  - Rx 03 01 04 05 → NAK response 03 01 04 EE EE, pa_en unchanged, one frame_err pulse.
  - Rx 02 01, idle TIMEOUT_CYC+1 cycles, then 02 01 03 00 → one frame_err pulse and exactly one response.
- Backpressure and dropped byte: tx_rdy low for 10 cycles on byte 2 → tx_byte held at 0x01 and tx_vld held. An rx byte injected during TX is dropped with a frame_err pulse, and the response still completes unchanged.
- Reset mid-TX: assert rst after 2 bytes sent → tx_vld = 0, pa_en = 0 immediately; after release, a new 02 01 01 00 frame returns 02 01 01 00 00.
